// File: rtl/ysyx_041514_if_fetch_if.sv
// ---------------------------------------------------------------------------
// ysyx_041514_if_fetch_if
//   Request/response bundle between the instruction-fetch stage and the
//   instruction memory port.
//
//   master : fetch stage   (drives request, consumes response)
//   slave  : memory side   (consumes request, drives response)
//
//   imem_req_valid_o   fetch request valid
//   imem_req_ready_i   memory accepts the request this cycle
//   imem_addr_o        fetch address (XLEN)
//   imem_resp_valid_i  response data valid
//   imem_resp_data_i   fetched instruction (INST_LEN)
//   imem_resp_err_i    access fault on this response
// ---------------------------------------------------------------------------
interface ysyx_041514_if_fetch_if #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
);
    logic                imem_req_valid_o;
    logic                imem_req_ready_i;
    logic [XLEN-1:0]     imem_addr_o;
    logic                imem_resp_valid_i;
    logic [INST_LEN-1:0] imem_resp_data_i;
    logic                imem_resp_err_i;

    modport master (
        output imem_req_valid_o, imem_addr_o,
        input  imem_req_ready_i, imem_resp_valid_i, imem_resp_data_i, imem_resp_err_i
    );

    modport slave (
        input  imem_req_valid_o, imem_addr_o,
        output imem_req_ready_i, imem_resp_valid_i, imem_resp_data_i, imem_resp_err_i
    );
endinterface

// File: rtl/ysyx_041514_if_fetch.sv
// ---------------------------------------------------------------------------
// ysyx_041514_if_fetch
//   Instruction-fetch stage. Owns the PC, runs one outstanding
//   request/response fetch against the instruction memory and presents
//   {inst_addr, inst_data, trap_bus} to the IF/ID register. A fetched
//   instruction is held until IF/ID accepts it; every other cycle carries a
//   bubble (PC_RESET_ADDR-4 / INST_NOP / 0) which IF/ID flushes.
//
//   clk, rst          clock, synchronous active-high reset
//   stall_valid_i     pipeline stall bus, bit 1 = IF/ID will not accept
//   redirect_valid_i  single-cycle redirect pulse
//   redirect_pc_i     redirect target
//   imem              instruction memory bundle (master side)
//   inst_addr_if_o    instruction address to IF/ID
//   inst_data_if_o    instruction to IF/ID
//   trap_bus_if_o     bit0 fetch misaligned, bit1 fetch access fault
//   if_busy_o         a fetch is in progress (REQ, RESP or DRAIN)
// ---------------------------------------------------------------------------
module ysyx_041514_if_fetch #(
    parameter int                 XLEN          = 64,
    parameter int                 INST_LEN      = 32,
    parameter int                 TRAP_LEN      = 32,
    parameter logic [XLEN-1:0]    PC_RESET_ADDR = 64'h8000_0000,
    parameter logic [INST_LEN-1:0] INST_NOP     = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall_valid_i,
    input  logic                  redirect_valid_i,
    input  logic [XLEN-1:0]       redirect_pc_i,
    ysyx_041514_if_fetch_if.master imem,
    output logic [XLEN-1:0]       inst_addr_if_o,
    output logic [INST_LEN-1:0]   inst_data_if_o,
    output logic [TRAP_LEN-1:0]   trap_bus_if_o,
    output logic                  if_busy_o
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_RESP  = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] BUBBLE_ADDR = PC_RESET_ADDR - XLEN'(4);

    state_t              state_q;
    logic [XLEN-1:0]     pc_q;
    logic [INST_LEN-1:0] inst_q;
    logic [TRAP_LEN-1:0] trap_q;

    logic pc_aligned;
    logic if_id_stall;
    logic present;

    // Only bit 1 of the shared stall bus concerns this stage.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall_valid_i[5:2], stall_valid_i[0]};

    assign pc_aligned  = (pc_q[1:0] == 2'b00);
    assign if_id_stall = stall_valid_i[1];

    // Misaligned PCs never reach the memory; the trap is raised locally.
    assign imem.imem_req_valid_o = (state_q == S_REQ) && pc_aligned;
    assign imem.imem_addr_o      = pc_q;

    // A redirect turns the held instruction into a bubble in the same cycle.
    assign present        = (state_q == S_HOLD) && !redirect_valid_i;
    assign inst_addr_if_o = present ? pc_q   : BUBBLE_ADDR;
    assign inst_data_if_o = present ? inst_q : INST_NOP;
    assign trap_bus_if_o  = present ? trap_q : '0;
    assign if_busy_o      = (state_q != S_HOLD);

    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= PC_RESET_ADDR;
            // NOTE: inst_q/trap_q are only visible in HOLD, but resetting them
            // keeps simulation free of X on the datapath after reset.
            inst_q  <= INST_NOP;
            trap_q  <= '0;
        end else if (redirect_valid_i) begin
            pc_q <= redirect_pc_i;
            unique case (state_q)
                // An accepted request is owed a response, so it must be drained.
                S_REQ:   state_q <= (imem.imem_req_valid_o && imem.imem_req_ready_i)
                                    ? S_DRAIN : S_REQ;
                S_RESP,
                S_DRAIN: state_q <= imem.imem_resp_valid_i ? S_REQ : S_DRAIN;
                S_HOLD:  state_q <= S_REQ;
                default: state_q <= S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (!pc_aligned) begin
                        inst_q  <= INST_NOP;
                        trap_q  <= TRAP_LEN'(1);
                        state_q <= S_HOLD;
                    end else if (imem.imem_req_ready_i) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (imem.imem_resp_valid_i) begin
                        inst_q  <= imem.imem_resp_err_i ? INST_NOP : imem.imem_resp_data_i;
                        trap_q  <= {{(TRAP_LEN-2){1'b0}}, imem.imem_resp_err_i, 1'b0};
                        state_q <= S_HOLD;
                    end
                end
                S_DRAIN: begin
                    // pc_q already holds the redirect target; drop the data.
                    if (imem.imem_resp_valid_i) begin
                        state_q <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (!if_id_stall) begin
                        pc_q    <= pc_q + XLEN'(4);
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

endmodule
